// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation encoding and operands in,
// status flags and the registered result out.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       alu_op;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, alu_op, funct7, funct3, a, b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, alu_op, funct7, funct3, a, b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial shifts and an
// optional radix-2 shift-add multiplier compiled in with `define ALU_SEQ_MUL_EN.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic     clk,
  input logic     reset,
  alu_seq_if.slave bus
);
  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {K_ALU, K_SLL, K_SRL, K_SRA, K_MUL, K_ILL} kind_t;

  state_t             state, state_next;
  kind_t              kind, run_kind;
  logic [WIDTH-1:0]   alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               multi;
  logic               accept;
  logic [CNT_W-1:0]   cnt, cnt_dec;
  logic [WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]   result;
  logic               illegal;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   mcand, mplier;
`endif

  assign shamt = bus.b[SHAMT_W-1:0];

  // Decode of the encoding presented with start; shift kinds pass a through
  // so a zero shift amount completes directly with result=a.
  always_comb begin
    kind    = K_ILL;
    alu_res = '0;
    case (bus.alu_op)
      2'b00: begin kind = K_ALU; alu_res = bus.a + bus.b; end
      2'b01: begin kind = K_ALU; alu_res = bus.a - bus.b; end
      2'b10: begin
        if (bus.funct7 == 7'b0000000) begin
          case (bus.funct3)
            3'b000: begin kind = K_ALU; alu_res = bus.a + bus.b; end
            3'b111: begin kind = K_ALU; alu_res = bus.a & bus.b; end
            3'b110: begin kind = K_ALU; alu_res = bus.a | bus.b; end
            3'b100: begin kind = K_ALU; alu_res = bus.a ^ bus.b; end
            3'b010: begin
              kind    = K_ALU;
              alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            end
            3'b001:  begin kind = K_SLL; alu_res = bus.a; end
            3'b101:  begin kind = K_SRL; alu_res = bus.a; end
            default: ;
          endcase
        end else if (bus.funct7 == 7'b0100000) begin
          case (bus.funct3)
            3'b000:  begin kind = K_ALU; alu_res = bus.a - bus.b; end
            3'b101:  begin kind = K_SRA; alu_res = bus.a; end
            default: ;
          endcase
`ifdef ALU_SEQ_MUL_EN
        end else if (bus.funct7 == 7'b0000001 && bus.funct3 == 3'b000) begin
          kind = K_MUL;
`endif
        end
      end
      default: begin
        case (bus.funct3)
          3'b000: begin kind = K_ALU; alu_res = bus.a + bus.b; end
          3'b110: begin kind = K_ALU; alu_res = bus.a | bus.b; end
          3'b111: begin kind = K_ALU; alu_res = bus.a & bus.b; end
          3'b100: begin kind = K_ALU; alu_res = bus.a ^ bus.b; end
          3'b001: begin
            if (bus.funct7 == 7'b0000000) begin kind = K_SLL; alu_res = bus.a; end
          end
          3'b101: begin
            if (bus.funct7 == 7'b0000000) begin
              kind = K_SRL; alu_res = bus.a;
            end else if (bus.funct7 == 7'b0100000) begin
              kind = K_SRA; alu_res = bus.a;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  assign multi  = ((kind == K_SLL || kind == K_SRL || kind == K_SRA) && shamt != '0)
                  || kind == K_MUL;
  assign accept = bus.start && state != S_RUN;
  assign cnt_dec = cnt - CNT_W'(1);

  always_comb begin
    acc_step = acc;
    case (run_kind)
      K_SLL:   acc_step = acc << 1;
      K_SRL:   acc_step = acc >> 1;
      K_SRA:   acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef ALU_SEQ_MUL_EN
      K_MUL:   acc_step = mplier[0] ? acc + mcand : acc;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN: if (cnt_dec == '0) state_next = S_DONE;
      default: begin
        if (bus.start)             state_next = multi ? S_RUN : S_DONE;
        else if (state == S_DONE)  state_next = S_IDLE;
      end
    endcase
  end

  // result/illegal are written only on the edge that enters DONE; acc holds
  // the in-flight shift or partial product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_kind <= K_ALU;
      cnt      <= '0;
      acc      <= '0;
      result   <= '0;
      illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand    <= '0;
      mplier   <= '0;
`endif
    end else if (accept) begin
      run_kind <= kind;
      acc      <= (kind == K_MUL) ? '0 : bus.a;
      cnt      <= (kind == K_MUL) ? CNT_W'(WIDTH) : {1'b0, shamt};
`ifdef ALU_SEQ_MUL_EN
      mcand    <= bus.a;
      mplier   <= bus.b;
`endif
      if (!multi) begin
        result  <= alu_res;
        illegal <= (kind == K_ILL);
      end
    end else if (state == S_RUN) begin
      acc <= acc_step;
      cnt <= cnt_dec;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`endif
      if (cnt_dec == '0) begin
        result  <= acc_step;
        illegal <= 1'b0;
      end
    end
  end

  assign bus.busy    = (state == S_RUN);
  assign bus.done    = (state == S_DONE);
  assign bus.result  = result;
  assign bus.zero    = (result == '0);
  assign bus.illegal = illegal;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; expected results are queued at issue time and
// retired when done is observed, with completion cycle checked against latency.
module tb_alu_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; retire or time out the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", bus.done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_result"},  bus.result,  e.res);
        chk({e.tag, "_illegal"}, bus.illegal, e.ill);
        chk({e.tag, "_zero"},    bus.zero,    (e.res == 32'h0));
        chk({e.tag, "_cycle"},   cyc,         e.due);
      end
    end else if (sb.size() != 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
      chk({e.tag, "_done"}, bus.done, 1'b1);
    end
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic ill, input int lat);
    bus.start  = 1'b1;
    bus.alu_op = op;
    bus.funct7 = f7;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    sb.push_back('{tag: tag, res: res, ill: ill, due: cyc + lat});
    step();
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    step();
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.alu_op = '0;
    bus.funct7 = '0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;
    #2;
    chk("rst_busy",    bus.busy,    1'b0);
    chk("rst_done",    bus.done,    1'b0);
    chk("rst_result",  bus.result,  32'h0);
    chk("rst_zero",    bus.zero,    1'b1);
    chk("rst_illegal", bus.illegal, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    issue("sub_r",  2'b10, 7'h20, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1); drain();
    issue("add_wr", 2'b00, 7'h00, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1); drain();
    issue("sub_op", 2'b01, 7'h00, 3'b000, 32'd10, 32'd3, 32'd7, 1'b0, 1); drain();
    issue("sub_z",  2'b01, 7'h00, 3'b000, 32'd9, 32'd9, 32'd0, 1'b0, 1); drain();
    issue("and_r",  2'b10, 7'h00, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1); drain();
    issue("or_r",   2'b10, 7'h00, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1); drain();
    issue("xor_r",  2'b10, 7'h00, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1); drain();
    issue("slt_t",  2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1); drain();
    issue("slt_f",  2'b10, 7'h00, 3'b010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1); drain();
    issue("addi",   2'b11, 7'h7F, 3'b000, 32'd10, 32'hFFFF_FFFF, 32'd9, 1'b0, 1); drain();
    issue("ori",    2'b11, 7'h00, 3'b110, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1); drain();
    issue("andi",   2'b11, 7'h00, 3'b111, 32'hFF, 32'hF0, 32'hF0, 1'b0, 1); drain();
    issue("xori",   2'b11, 7'h00, 3'b100, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1); drain();

    // sra by 4 with ignored start pulses during RUN
    issue("sra", 2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5);
    chk("sra_busy0", bus.busy, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      bus.start  = (i != 2);
      bus.alu_op = 2'b00;
      bus.a      = 32'd1;
      bus.b      = 32'd1;
      step();
      chk($sformatf("sra_busy%0d", i), bus.busy, 1'b1);
    end
    bus.start = 1'b0;
    step();
    chk("sra_busy_end", bus.busy, 1'b0);
    drain();

    issue("srl",   2'b10, 7'h00, 3'b101, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 32); drain();
    issue("sll",   2'b10, 7'h00, 3'b001, 32'd1, 32'h23, 32'd8, 1'b0, 4); drain();
    issue("slli",  2'b11, 7'h00, 3'b001, 32'd3, 32'd2, 32'hC, 1'b0, 3); drain();
    issue("srai",  2'b11, 7'h20, 3'b101, 32'hF000_0000, 32'd8, 32'hFFF0_0000, 1'b0, 9); drain();
    issue("srli",  2'b11, 7'h00, 3'b101, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 5); drain();

    // back-to-back: second start presented in the DONE cycle of the first
    issue("sll0",     2'b10, 7'h00, 3'b001, 32'h1234, 32'd0, 32'h1234, 1'b0, 1);
    issue("addi_b2b", 2'b11, 7'h00, 3'b000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    drain();

    issue("add_pre", 2'b00, 7'h00, 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1); drain();
    issue("ill_slli", 2'b11, 7'h20, 3'b001, 32'd5, 32'd1, 32'd0, 1'b1, 1); drain();
    issue("ill_r011", 2'b10, 7'h00, 3'b011, 32'd3, 32'd4, 32'd0, 1'b1, 1); drain();
    issue("ill_clr",  2'b00, 7'h00, 3'b000, 32'd4, 32'd4, 32'd8, 1'b0, 1); drain();

`ifdef ALU_SEQ_MUL_EN
    issue("mul",    2'b10, 7'h01, 3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 33); drain();
    issue("mul_m1", 2'b10, 7'h01, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33); drain();
    issue("mul_long", 2'b10, 7'h01, 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 33);
`else
    issue("mul_off", 2'b10, 7'h01, 3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b1, 1); drain();
    issue("add_pre2", 2'b00, 7'h00, 3'b000, 32'd2, 32'd1, 32'd3, 1'b0, 1); drain();
    issue("srl_long", 2'b10, 7'h00, 3'b101, 32'hFFFF_FFFF, 32'd31, 32'd1, 1'b0, 32);
`endif
    // abort the long operation with an asynchronous reset between edges
    for (int i = 0; i < 5; i++) step();
    chk("abort_busy_pre", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy",    bus.busy,    1'b0);
    chk("abort_done",    bus.done,    1'b0);
    chk("abort_result",  bus.result,  32'h0);
    chk("abort_zero",    bus.zero,    1'b1);
    chk("abort_illegal", bus.illegal, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("abort_idle", bus.busy, 1'b0);

    issue("post_rst", 2'b00, 7'h00, 3'b000, 32'd2, 32'd3, 32'd5, 1'b0, 1); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
